// File: rtl/clock_pkg.sv
// Shared definitions for the clock/time controller: field widths, wrap limits
// and the mode (FSM state) encoding.
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int MODE_W = 2;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd11;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_SEC  = 2'b11
    } mode_t;

    // Increment a seconds/minutes field, wrapping to zero past its limit.
    function automatic logic [5:0] wrap_inc6(input logic [5:0] value, input logic [5:0] limit);
        return (value == limit) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: two-flop synchronizer into vga_clk, then a
// level filter that only follows the input after DEB_CYCLES consecutive
// samples disagreeing with the current level. A debounced rising edge gives
// a one-cycle press pulse, coincident with the first cycle of the new level.
module btn_debounce #(
    parameter int DEB_CYCLES = 400_000
) (
    input  logic vga_clk,
    input  logic sys_rstn,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the vga_clk domain.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// 12-hour clock controller: debounced mode/inc buttons drive a four-state
// RUN/SET FSM, a prescaler produces one-second ticks while running, and the
// displayed time is refreshed from the working registers on frame_start only.
// Optional feature: define CLOCK_CTRL_AUTOREPEAT_EN to auto-repeat the inc
// button every REPEAT_CYCLES while it stays held.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_FREQ      = 40_000_000,
    parameter int DEB_CYCLES    = 400_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              vga_clk,
    input  logic              sys_rstn,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              frame_start,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [MODE_W-1:0] mode,
    output logic              sec_tick
);

    localparam int PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);

    logic              mode_level;
    logic              mode_press;
    logic              inc_level;
    logic              inc_press;
    logic              mode_evt;
    logic              inc_evt;
    mode_t             state;
    mode_t             state_next;
    logic [PRE_W-1:0]  presc;
    logic              tick;
    logic [SEC_W-1:0]  sec_w;
    logic [MIN_W-1:0]  min_w;
    logic [HOUR_W-1:0] hour_w;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .vga_clk  (vga_clk),
        .sys_rstn (sys_rstn),
        .btn_raw  (btn_mode),
        .level    (mode_level),
        .press    (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .vga_clk  (vga_clk),
        .sys_rstn (sys_rstn),
        .btn_raw  (btn_inc),
        .level    (inc_level),
        .press    (inc_press)
    );

    // A press pulse always coincides with a high debounced level.
    assign mode_evt = mode_press && mode_level;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_hit;

    assign rep_hit = inc_level && !inc_press && (rep_cnt == REP_LAST);

    // Repeat timer: restarts on each (real or repeated) press, release or mode change.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rep_cnt <= '0;
        end else if (!inc_level || inc_press || mode_evt || rep_hit) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    // Mode press wins over a coincident inc (real or repeated).
    assign inc_evt = (inc_press || rep_hit) && !mode_evt;
`else
    // Mode press wins over a coincident inc press.
    assign inc_evt = inc_press && inc_level && !mode_evt;
`endif

    // FSM state register.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state <= MODE_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: one step around the ring per mode press.
    always_comb begin
        state_next = state;
        if (mode_evt) begin
            case (state)
                MODE_RUN:      state_next = MODE_SET_HOUR;
                MODE_SET_HOUR: state_next = MODE_SET_MIN;
                MODE_SET_MIN:  state_next = MODE_SET_SEC;
                default:       state_next = MODE_RUN;
            endcase
        end
    end

    // FSM outputs: visible mode and the one-second tick.
    always_comb begin
        mode     = state;
        tick     = (state == MODE_RUN) && (presc == PRE_LAST);
        sec_tick = tick;
    end

    // Prescaler runs only in RUN, so re-entering RUN restarts a full second.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            presc <= '0;
        end else if ((state != MODE_RUN) || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Working time: carry chain on tick, per-field edits in the set states.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sec_w  <= '0;
            min_w  <= '0;
            hour_w <= '0;
        end else if (tick) begin
            sec_w <= wrap_inc6(sec_w, SEC_MAX);
            if (sec_w == SEC_MAX) begin
                min_w <= wrap_inc6(min_w, MIN_MAX);
                if (min_w == MIN_MAX) begin
                    hour_w <= (hour_w == HOUR_MAX) ? '0 : hour_w + 1'b1;
                end
            end
        end else if (inc_evt) begin
            case (state)
                MODE_SET_HOUR: hour_w <= (hour_w == HOUR_MAX) ? '0 : hour_w + 1'b1;
                MODE_SET_MIN:  min_w  <= wrap_inc6(min_w, MIN_MAX);
                MODE_SET_SEC:  sec_w  <= '0;
                default:       ;
            endcase
        end
    end

    // Display copy once per frame so the picture never tears mid-update.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sec  <= '0;
            min  <= '0;
            hour <= '0;
        end else if (frame_start) begin
            sec  <= sec_w;
            min  <= min_w;
            hour <= hour_w;
        end
    end

endmodule

// File: doc/clock_time_ctrl.md
CLOCK_TIME_CTRL -- requirements
Module: clock_time_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 40_000_000, vga_clk cycles per second.
REQ-002 SHALL have parameter DEB_CYCLES, default 400_000, stable-level cycles required to accept a button change.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10_000_000, auto-repeat period.
REQ-004 SHALL have port: vga_clk  in  1  pixel/system clock.
REQ-005 SHALL have port: sys_rstn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: btn_mode  in  1  raw mode button, active-high, asynchronous to vga_clk.
REQ-007 SHALL have port: btn_inc  in  1  raw increment button, active-high, asynchronous.
REQ-008 SHALL have port: frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-009 SHALL have port: sec  out  6  displayed seconds, 0..59.
REQ-010 SHALL have port: min  out  6  displayed minutes, 0..59.
REQ-011 SHALL have port: hour  out  5  displayed hours, 0..11.
REQ-012 SHALL have port: mode  out  2  current FSM state.
REQ-013 SHALL have port: sec_tick  out  1  one-cycle pulse on each running-second increment.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer, then a debouncer updating its level only after DEB_CYCLES consecutive equal samples; a debounced 0->1 edge yields one-cycle press pulse.
REQ-015 SHALL implement FSM RUN(00) -> SET_HOUR(01) -> SET_MIN(10) -> SET_SEC(11) -> RUN, advancing one state per mode press.
REQ-016 SHALL count prescaler 0..CLK_FREQ-1 only in RUN; tick at CLK_FREQ-1, prescaler to 0; held at 0 outside RUN.
REQ-017 SHALL on tick increment working seconds; 59->0 carries minutes; minutes 59->0 carries hours; hours 11->0; sec_tick high in the same cycle.
REQ-018 SHALL on inc press: SET_HOUR hour=(hour+1) mod 12; SET_MIN min=(min+1) mod 60, no carry; SET_SEC sec=0; RUN ignored.
REQ-019 SHALL give mode press priority when mode and inc press coincide; inc press discarded.
REQ-020 SHALL copy working registers to sec/min/hour outputs in the frame_start cycle (visible next cycle), outputs otherwise stable.
REQ-021 SHALL, when tick and frame_start coincide, copy pre-increment values; new value appears at next frame_start.
REQ-022 SHALL on SET_SEC->RUN restart prescaler at 0; first tick exactly CLK_FREQ cycles after entering RUN.
REQ-023 SHALL drive mode combinationally from the FSM state register.

Reset
REQ-024 SHALL on sys_rstn low asynchronously clear prescaler, working time, outputs sec/min/hour to 0, sec_tick 0, mode RUN, debounced levels 0.
REQ-025 SHALL treat a button held through reset release as a new press after DEB_CYCLES.
REQ-026 SHALL abandon any in-progress debounce or set operation on reset, retaining no prior value.

Configuration
REQ-027 SHALL with CLOCK_CTRL_AUTOREPEAT_EN defined generate an extra inc press every REPEAT_CYCLES while debounced btn_inc stays high, first repeat REPEAT_CYCLES after the initial press; repeat counter cleared on release or mode change.
REQ-028 SHALL without CLOCK_CTRL_AUTOREPEAT_EN produce exactly one inc press per debounced rising edge; REPEAT_CYCLES unused.

Structure
REQ-029 SHALL place mode encodings, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=11 and field widths in shared package clock_pkg.
REQ-030 SHALL implement synchronizer+debouncer as sub-module btn_debounce, instantiated twice.

Verification (CLK_FREQ=100, DEB_CYCLES=4, REPEAT_CYCLES=20, frame_start tied high unless stated)
REQ-031 SHALL cover: reset, run 6000 cycles -> min=1, sec=0, hour=0; 60 sec_tick pulses.
REQ-032 SHALL cover: set hour=11, min=59, sec=0 via buttons, run 59 ticks then 1 more -> 0:00:00.
REQ-033 SHALL cover: btn_inc high 3 cycles in SET_MIN -> min unchanged; high 10 cycles -> min+1 exactly once.
REQ-034 SHALL cover: frame_start pulsed in tick cycle with sec=5 -> output sec=5, next frame_start -> 6.
REQ-035 SHALL cover: four mode presses -> mode 01,10,11,00; first sec_tick 100 cycles after RUN entry; simultaneous mode+inc -> mode advances, field unchanged.
REQ-036 SHALL cover (macro defined): hold btn_inc 70 debounced cycles in SET_MIN from min=0 -> min=4; undefined -> min=1.
